// File: rtl/inv_ark_mix_round.sv
// AES decryption stage: AddRoundKey, then InvMixColumns one column per cycle, with valid/ready on both sides.
// Optional feature macro: AES_ARK_LAST_EN adds last_round, which skips InvMixColumns for the final round.
module inv_ark_mix_round (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
`ifdef AES_ARK_LAST_EN
  input  logic         last_round,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] state_out,
  output logic         busy
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [0:STATE_W-1] work_q, work_d;
  logic [1:0]         col_q, col_d;
  logic               skip_c;
  logic [COL_W-1:0]   col_in_c;
  logic [6:0]         col_base_c;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 09/0b/0d/0e built from the x2, x4, x8 chain
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      x1[i] = a[31-8*i -: 8];
      x2[i] = xtime(x1[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ x1[i];
      mb[i] = x8[i] ^ x2[i] ^ x1[i];
      md[i] = x8[i] ^ x4[i] ^ x1[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef AES_ARK_LAST_EN
  assign skip_c = last_round;
`else
  assign skip_c = 1'b0;
`endif

  assign col_base_c = {col_q, 5'd0};
  assign col_in_c   = work_q[col_base_c +: COL_W];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = state_in ^ round_key;
          col_d   = 2'd0;
          state_d = skip_c ? DONE : MIX;
        end
      end
      MIX: begin
        work_d[col_base_c +: COL_W] = inv_mix_col(col_in_c);
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      col_q     <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      col_q     <= col_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign state_out = work_q;

endmodule

// File: tb/tb_inv_ark_mix_round.sv
// Directed self-checking bench for inv_ark_mix_round: vector table plus handshake/reset sequences.
module tb_inv_ark_mix_round;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] state_in;
  logic [0:127] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] state_out;
  logic         busy;
`ifdef AES_ARK_LAST_EN
  logic         last_round;
`endif

  int n_cmp = 0;
  int n_err = 0;

  inv_ark_mix_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
`ifdef AES_ARK_LAST_EN
    .last_round(last_round),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for out_valid, counting rising edges since the accept edge
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL timeout waiting for out_valid after %0d cycles", lat);
    end
  endtask

  task automatic accept(input logic [127:0] st, input logic [127:0] key);
    @(negedge clk);
    state_in  = st;
    round_key = key;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] MIX_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] MIX_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;

  vec_t vecs [6];
  int   lat;

  initial begin
    vecs[0] = '{MIX_IN, 128'h0, MIX_OUT};
    vecs[1] = '{128'h0, MIX_IN, MIX_OUT};
    vecs[2] = '{128'h71b25e43_6023a762_fefefefe_39393939, {128{1'b1}}, MIX_OUT};
    vecs[3] = '{128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d, 128'h0,
                128'hc6c6c6c6_01010101_db135345_f20a225c};
    vecs[4] = '{128'h046681e5_00000000_00000000_00000000, 128'h0,
                128'hd4bf5d30_00000000_00000000_00000000};
    vecs[5] = '{128'h0123_4567_89ab_cdef_0011_2233_4455_6677,
                128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 128'h0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    state_in = '0; round_key = '0;
`ifdef AES_ARK_LAST_EN
    last_round = 1'b0;
`endif
    #12;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_state_out", state_out, 128'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].st, vecs[i].key);
      wait_valid(lat);
      chk($sformatf("vec%0d_result", i), state_out, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      drain();
    end

    // Backpressure: hold out_ready low, present a new block that must be ignored
    accept(MIX_IN, 128'h0);
    wait_valid(lat);
    @(negedge clk);
    state_in = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_state_out", i), state_out, MIX_OUT);
      chk($sformatf("bp%0d_out_valid", i), 128'(out_valid), 128'd1);
      chk($sformatf("bp%0d_in_ready", i), 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);

    // Reset two cycles into MIX aborts the block
    accept(MIX_IN, 128'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_state_out", state_out, 128'h0);
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    chk("rst_mid_busy", 128'(busy), 128'd0);
    @(negedge clk); rst = 1'b0;
    accept(128'h0, MIX_IN);
    wait_valid(lat);
    chk("rst_after_result", state_out, MIX_OUT);
    chk("rst_after_latency", 128'(lat), 128'd4);
    drain();

`ifdef AES_ARK_LAST_EN
    @(negedge clk);
    last_round = 1'b1;
    accept(128'h00112233_44556677_8899aabb_ccddeeff, {128{1'b1}});
    last_round = 1'b0;
    wait_valid(lat);
    chk("last_result", state_out, 128'hffeeddcc_bbaa9988_77665544_33221100);
    chk("last_latency", 128'(lat), 128'd0);
    drain();
`endif

    // Back-to-back: in_valid and out_ready held high across two blocks
    @(negedge clk);
    state_in = MIX_IN; round_key = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    state_in = 128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d;
    wait_valid(lat);
    chk("b2b_first_result", state_out, MIX_OUT);
    chk("b2b_first_latency", 128'(lat), 128'd4);
    @(posedge clk); #1;
    chk("b2b_hs_in_ready", 128'(in_ready), 128'd1);
    chk("b2b_hs_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    chk("b2b_second_accept_busy", 128'(busy), 128'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_valid(lat);
    chk("b2b_second_result", state_out, 128'hc6c6c6c6_01010101_db135345_f20a225c);
    chk("b2b_second_latency", 128'(lat), 128'd4);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
